// File: rtl/i_buffer_pkg.sv
// ----------------------------------------------------------------------------
// i_buffer_pkg
// Decode-side field sizes, RV32 base opcode values and the packed entry
// width shared by the instruction buffer and its storage FIFO.
// No ports (package).
// ----------------------------------------------------------------------------
package i_buffer_pkg;

   localparam int OPT_SIZE       = 7;
   localparam int FUNCT_SIZE     = 3;
   localparam int REG_SIZE       = 5;
   localparam int DEF_DATA_WIDTH = 32;

   // Packed entry layout, MSB to LSB: {opt, funct, rs1, rs2, rd, imm}
   localparam int ENTRY_WIDTH = OPT_SIZE + FUNCT_SIZE + 3 * REG_SIZE + DEF_DATA_WIDTH;

   localparam logic [OPT_SIZE-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPT_SIZE-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPT_SIZE-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPT_SIZE-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPT_SIZE-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPT_SIZE-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPT_SIZE-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPT_SIZE-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPT_SIZE-1:0] OPC_OP     = 7'b0110011;

   // Entry width for an arbitrary immediate width
   function automatic int entry_width(input int data_width);
      return OPT_SIZE + FUNCT_SIZE + 3 * REG_SIZE + data_width;
   endfunction

endpackage

// File: rtl/i_buffer_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Circular FIFO with head/tail pointers, an occupancy counter and a
// single-cycle flush. Callers must not push when full or pop when empty.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (pointers and count only)
//   flush    in   empty the FIFO this cycle; overrides push/pop
//   i_push   in   write i_wdata at tail
//   i_pop    in   advance head
//   i_wdata  in   WIDTH   write data
//   o_rdata  out  WIDTH   entry at head (undefined content when empty)
//   o_count  out  $clog2(DEPTH)+1  occupied entries
// ----------------------------------------------------------------------------
module sync_fifo
   import i_buffer_pkg::*;
#(
   parameter int WIDTH = ENTRY_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic             w_wr_en;

   // Storage is never cleared; a flushed entry is unreachable once the
   // pointers return to zero.
   assign w_wr_en = i_push && !rst && !flush;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_tail] <= i_wdata;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + AW'(1);
         if (i_pop)  r_head <= r_head + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_head];
   assign o_count = r_count;

endmodule

// File: rtl/i_buffer.sv
// ----------------------------------------------------------------------------
// i_buffer
// Instruction buffer between decode and issue. Packs one decoded
// instruction per cycle into a FIFO and presents the oldest entry to issue
// over a valid/ready handshake. Flush empties it in one cycle.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   flush                     in   discard all entries this cycle
//   id_valid                  in   decoder offers an instruction
//   id_vacant                 out  buffer accepts this cycle
//   id_opt/funct/rs1/rs2/rd   in   7/3/5/5/5 instruction fields
//   id_imm                    in   DATA_WIDTH immediate
//   is_valid                  out  head entry available
//   is_ready                  in   issue consumes head
//   is_opt/funct/rs1/rs2/rd   out  head fields (zero when empty)
//   is_imm                    out  head immediate (zero when empty)
//   count                     out  occupied entries
// ----------------------------------------------------------------------------
module i_buffer
   import i_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     id_valid,
   output logic                     id_vacant,
   input  logic [OPT_SIZE-1:0]      id_opt,
   input  logic [FUNCT_SIZE-1:0]    id_funct,
   input  logic [REG_SIZE-1:0]      id_rs1,
   input  logic [REG_SIZE-1:0]      id_rs2,
   input  logic [REG_SIZE-1:0]      id_rd,
   input  logic [DATA_WIDTH-1:0]    id_imm,
   output logic                     is_valid,
   input  logic                     is_ready,
   output logic [OPT_SIZE-1:0]      is_opt,
   output logic [FUNCT_SIZE-1:0]    is_funct,
   output logic [REG_SIZE-1:0]      is_rs1,
   output logic [REG_SIZE-1:0]      is_rs2,
   output logic [REG_SIZE-1:0]      is_rd,
   output logic [DATA_WIDTH-1:0]    is_imm,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int              EW       = entry_width(DATA_WIDTH);
   localparam int              CW       = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

   logic          w_push;
   logic          w_pop;
   logic [EW-1:0] w_wdata;
   logic [EW-1:0] w_rdata;
   logic [EW-1:0] w_head;

   // No room is made by a same-cycle pop, so vacancy never depends on
   // is_ready; rst/flush close the input so nothing is half-accepted.
   assign id_vacant = (count != FULL_CNT) && !rst && !flush;
   assign is_valid  = (count != '0);

   assign w_push  = id_valid && id_vacant;
   assign w_pop   = is_valid && is_ready;
   assign w_wdata = {id_opt, id_funct, id_rs1, id_rs2, id_rd, id_imm};

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata),
      .o_count (count)
   );

   // Stale storage must not leak out while empty
   assign w_head = is_valid ? w_rdata : '0;
   assign {is_opt, is_funct, is_rs1, is_rs2, is_rd, is_imm} = w_head;

endmodule
